inter_nxm_arb: RTL and testbench

- Parametrised N-master to M-slave request interconnect.
- Each master deposits one {slave, addr, value} request into its own holding register.
- An arbiter (fixed-priority or round-robin) picks one pending request and drives it to the addressed slave over a valid/ready handshake.
- It reports completion with a one-cycle handshake pulse and sits between the master-side request generators and the slave register blocks.

---
 rtl/inter_nxm_arb_if.sv | 56 +++++
 rtl/inter_nxm_arb.sv | 188 ++++++++++++++++++
 tb/tb_inter_nxm_arb.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/inter_nxm_arb_if.sv
// -----------------------------------------------------------------------------
// inter_nxm_arb_if
//   Bundles the request side (masters -> interconnect) and the issue side
//   (interconnect -> slaves) of the N-master / M-slave request interconnect.
//
//   modport slave  : view of the interconnect itself (it is the slave of the
//                    request masters and drives the slave-facing bus).
//   modport master : view of the environment around it (request generators
//                    and slave register blocks).
//
//   in_valid        N_MST        per-master request strobe
//   data_in         N_MST*D_W    master i word at [i*D_W +: D_W], {slv,addr,value}
//   in_ready        N_MST        master i holding register free
//   ready_slave     N_SLV        slave accepts
//   valid_slave     N_SLV        one-hot request to slave
//   addr_out        ADDR_W       address of granted request
//   value_out       VAL_W        value of granted request
//   handshake_slave N_SLV        one-cycle completion pulse per slave
//   grant_id        MID_W        index of master currently served
//   busy            1            transfer in progress
//   decode_err      1            one-cycle pulse, slave field out of range
// -----------------------------------------------------------------------------
interface inter_nxm_arb_if #(
    parameter int N_MST  = 4,
    parameter int N_SLV  = 4,
    parameter int ADDR_W = 3,
    parameter int VAL_W  = 3
);
    localparam int SLV_W = $clog2(N_SLV);
    localparam int MID_W = $clog2(N_MST);
    localparam int D_W   = SLV_W + ADDR_W + VAL_W;

    logic [N_MST-1:0]     in_valid;
    logic [N_MST*D_W-1:0] data_in;
    logic [N_MST-1:0]     in_ready;
    logic [N_SLV-1:0]     ready_slave;
    logic [N_SLV-1:0]     valid_slave;
    logic [ADDR_W-1:0]    addr_out;
    logic [VAL_W-1:0]     value_out;
    logic [N_SLV-1:0]     handshake_slave;
    logic [MID_W-1:0]     grant_id;
    logic                 busy;
    logic                 decode_err;

    modport slave (
        input  in_valid, data_in, ready_slave,
        output in_ready, valid_slave, addr_out, value_out,
               handshake_slave, grant_id, busy, decode_err
    );

    modport master (
        output in_valid, data_in, ready_slave,
        input  in_ready, valid_slave, addr_out, value_out,
               handshake_slave, grant_id, busy, decode_err
    );
endinterface

// File: rtl/inter_nxm_arb.sv
// -----------------------------------------------------------------------------
// inter_nxm_arb
//   N-master to M-slave request interconnect. Every master owns one holding
//   register for a {slv, addr, value} request. An arbiter (fixed priority,
//   highest index wins, or round-robin) picks one pending request, drives it
//   to the addressed slave with valid/ready and reports completion with a
//   one-cycle handshake pulse on that slave's line. Requests addressing a
//   non-existent slave are dropped with a one-cycle decode_err pulse.
//
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    inter_nxm_arb_if.slave, all request / issue / status signals
// -----------------------------------------------------------------------------
module inter_nxm_arb #(
    parameter int N_MST   = 4,
    parameter int N_SLV   = 4,
    parameter int ADDR_W  = 3,
    parameter int VAL_W   = 3,
    parameter int RR_MODE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    inter_nxm_arb_if.slave bus
);
    localparam int SLV_W = $clog2(N_SLV);
    localparam int MID_W = $clog2(N_MST);
    localparam int D_W   = SLV_W + ADDR_W + VAL_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HS
    } state_e;

    state_e            state_q, state_d;
    logic [N_MST-1:0]  pend_q, pend_d, pend_clr, cap, in_rdy;
    logic [D_W-1:0]    req_q [N_MST];
    logic [MID_W-1:0]  ptr_q, ptr_d;
    logic [MID_W-1:0]  grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [VAL_W-1:0]  value_q, value_d;
    logic [N_SLV-1:0]  vs_q, vs_d;
    logic [N_SLV-1:0]  hs_q, hs_d;
    logic              derr_q, derr_d;

    logic              any_pend;
    logic [MID_W-1:0]  win;
    logic [D_W-1:0]    win_req;
    logic [SLV_W-1:0]  win_slv;

    function automatic logic [MID_W-1:0] next_ptr(input logic [MID_W-1:0] g);
        return (int'(g) == N_MST - 1) ? '0 : g + MID_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Capture: a holding register is free whenever it is not pending, but
    // never during reset.
    // ------------------------------------------------------------------
    assign in_rdy       = {N_MST{rst_n}} & ~pend_q;
    assign cap          = bus.in_valid & in_rdy;
    // pend can never be set and cleared together: capture needs !pend.
    assign pend_d       = (pend_q & ~pend_clr) | cap;
    assign bus.in_ready = in_rdy;

    // ------------------------------------------------------------------
    // Arbiter: works on the registered pend vector only, so a request
    // captured on the arbitration edge waits for the next arbitration.
    // ------------------------------------------------------------------
    assign any_pend = |pend_q;

    always_comb begin : arb
        int idx;
        // NOTE: every always_comb output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        win = '0;
        idx = 0;
        if (RR_MODE != 0) begin
            // Descending scan: the last hit is the one closest above the
            // pointer (with wrap), which is the round-robin winner.
            for (int k = N_MST - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= N_MST) idx = idx - N_MST;
                if (pend_q[idx]) win = MID_W'(idx);
            end
        end else begin
            // Ascending scan: the highest pending index wins.
            for (int i = 0; i < N_MST; i++) begin
                if (pend_q[i]) win = MID_W'(i);
            end
        end
    end

    assign win_req = req_q[win];
    assign win_slv = win_req[D_W-1 -: SLV_W];

    // ------------------------------------------------------------------
    // Transfer FSM: next state and registered outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        value_d  = value_q;
        vs_d     = vs_q;
        hs_d     = '0;
        derr_d   = 1'b0;
        pend_clr = '0;

        unique case (state_q)
            // HS arbitrates exactly like IDLE; the handshake pulse drops
            // because hs_d defaults to zero.
            S_IDLE, S_HS: begin
                state_d = S_IDLE;
                if (any_pend) begin
                    grant_d = win;
                    if (int'(win_slv) >= N_SLV) begin
                        // Unroutable request: drop it, never raise valid.
                        pend_clr[win] = 1'b1;
                        derr_d        = 1'b1;
                        ptr_d         = next_ptr(win);
                    end else begin
                        vs_d    = N_SLV'(1) << win_slv;
                        addr_d  = win_req[VAL_W +: ADDR_W];
                        value_d = win_req[VAL_W-1:0];
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Only the addressed slave's ready counts.
                if (|(vs_q & bus.ready_slave)) begin
                    pend_clr[grant_q] = 1'b1;
                    vs_d              = '0;
                    addr_d            = '0;
                    value_d           = '0;
                    hs_d              = vs_q;
                    ptr_d             = next_ptr(grant_q);
                    state_d           = S_HS;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            value_q <= '0;
            vs_q    <= '0;
            hs_q    <= '0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            vs_q    <= vs_d;
            hs_q    <= hs_d;
            derr_q  <= derr_d;
        end
    end

    // NOTE: the request payload registers have no reset; their contents are
    // only ever read while the matching pend bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_MST; i++) begin
            if (cap[i]) req_q[i] <= bus.data_in[i*D_W +: D_W];
        end
    end

    assign bus.valid_slave     = vs_q;
    assign bus.addr_out        = addr_q;
    assign bus.value_out       = value_q;
    assign bus.handshake_slave = hs_q;
    assign bus.grant_id        = grant_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.decode_err      = derr_q;

endmodule

// File: tb/tb_inter_nxm_arb.sv
// -----------------------------------------------------------------------------
// tb_inter_nxm_arb
//   Three instances: round-robin 4x4 (table-driven vectors plus a refill
//   sequence), fixed-priority 4x4 (simultaneous requests) and round-robin
//   4x3 (decode error). Inputs change 1 time unit after a rising edge,
//   outputs are compared 1 time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_inter_nxm_arb;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inter_nxm_arb_if #(.N_MST(4), .N_SLV(4), .ADDR_W(3), .VAL_W(3)) rr_if ();
    inter_nxm_arb_if #(.N_MST(4), .N_SLV(4), .ADDR_W(3), .VAL_W(3)) fp_if ();
    inter_nxm_arb_if #(.N_MST(4), .N_SLV(3), .ADDR_W(3), .VAL_W(3)) n3_if ();

    inter_nxm_arb #(.N_MST(4), .N_SLV(4), .ADDR_W(3), .VAL_W(3), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(rr_if)
    );
    inter_nxm_arb #(.N_MST(4), .N_SLV(4), .ADDR_W(3), .VAL_W(3), .RR_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .bus(fp_if)
    );
    inter_nxm_arb #(.N_MST(4), .N_SLV(3), .ADDR_W(3), .VAL_W(3), .RR_MODE(1)) u_n3 (
        .clk(clk), .rst_n(rst_n), .bus(n3_if)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst_n;
        logic [3:0]  in_valid;
        logic [31:0] data;
        logic [3:0]  ready;
        logic [3:0]  in_ready;
        logic [3:0]  valid_slave;
        logic [2:0]  addr;
        logic [2:0]  value;
        logic [3:0]  hs;
        logic [1:0]  grant;
        logic        busy;
        logic        derr;
    } vec_t;

    function automatic vec_t v(input logic r, input logic [3:0] iv, input logic [31:0] d,
                               input logic [3:0] rdy, input logic [3:0] e_inr,
                               input logic [3:0] e_vs, input logic [2:0] e_a,
                               input logic [2:0] e_v, input logic [3:0] e_hs,
                               input logic [1:0] e_g, input logic e_b, input logic e_d);
        vec_t t;
        t.rst_n = r;      t.in_valid = iv;    t.data = d;       t.ready = rdy;
        t.in_ready = e_inr; t.valid_slave = e_vs; t.addr = e_a; t.value = e_v;
        t.hs = e_hs;      t.grant = e_g;      t.busy = e_b;     t.derr = e_d;
        return t;
    endfunction

    vec_t tbl [18];
    int   exp_seq [6];
    int   got;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rr_if.in_valid = '0; rr_if.data_in = '0; rr_if.ready_slave = '0;
        fp_if.in_valid = '0; fp_if.data_in = '0; fp_if.ready_slave = '0;
        n3_if.in_valid = '0; n3_if.data_in = '0; n3_if.ready_slave = '0;

        // Words: 0x6E = {1,5,6}  0x99 = {2,3,1}  0x3A = {0,7,2}
        //        rst iv       data          rdy      in_rdy   valid    a  v  hs       g  b  d
        tbl[0]  = v(0, 4'b0000, 32'h0000_0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        tbl[1]  = v(1, 4'b0000, 32'h0000_0000, 4'b1111, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        tbl[2]  = v(1, 4'b0001, 32'h0000_006E, 4'b1111, 4'b1110, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        tbl[3]  = v(1, 4'b0000, 32'h0000_006E, 4'b1111, 4'b1110, 4'b0010, 5, 6, 4'b0000, 0, 1, 0);
        tbl[4]  = v(1, 4'b0000, 32'h0000_006E, 4'b1111, 4'b1111, 4'b0000, 0, 0, 4'b0010, 0, 1, 0);
        tbl[5]  = v(1, 4'b0000, 32'h0000_006E, 4'b1111, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        tbl[6]  = v(1, 4'b0010, 32'h0000_9900, 4'b1011, 4'b1101, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        tbl[7]  = v(1, 4'b0000, 32'h0000_9900, 4'b1011, 4'b1101, 4'b0100, 3, 1, 4'b0000, 1, 1, 0);
        tbl[8]  = v(1, 4'b0000, 32'h0000_9900, 4'b1011, 4'b1101, 4'b0100, 3, 1, 4'b0000, 1, 1, 0);
        tbl[9]  = v(1, 4'b0010, 32'h0000_FF00, 4'b1011, 4'b1101, 4'b0100, 3, 1, 4'b0000, 1, 1, 0);
        tbl[10] = v(1, 4'b0000, 32'h0000_FF00, 4'b1011, 4'b1101, 4'b0100, 3, 1, 4'b0000, 1, 1, 0);
        tbl[11] = v(1, 4'b0000, 32'h0000_FF00, 4'b1011, 4'b1101, 4'b0100, 3, 1, 4'b0000, 1, 1, 0);
        tbl[12] = v(1, 4'b0000, 32'h0000_FF00, 4'b1111, 4'b1111, 4'b0000, 0, 0, 4'b0100, 1, 1, 0);
        tbl[13] = v(1, 4'b0000, 32'h0000_FF00, 4'b1111, 4'b1111, 4'b0000, 0, 0, 4'b0000, 1, 0, 0);
        tbl[14] = v(1, 4'b0100, 32'h003A_0000, 4'b0000, 4'b1011, 4'b0000, 0, 0, 4'b0000, 1, 0, 0);
        tbl[15] = v(1, 4'b0000, 32'h003A_0000, 4'b0000, 4'b1011, 4'b0001, 7, 2, 4'b0000, 2, 1, 0);
        tbl[16] = v(0, 4'b0000, 32'h003A_0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        tbl[17] = v(1, 4'b0000, 32'h003A_0000, 4'b1111, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);

        #1;
        // ---------------- table-driven vectors on the round-robin 4x4 -----
        for (int i = 0; i < 18; i++) begin
            rst_n             = tbl[i].rst_n;
            rr_if.in_valid    = tbl[i].in_valid;
            rr_if.data_in     = tbl[i].data;
            rr_if.ready_slave = tbl[i].ready;
            step();
            check($sformatf("row%0d in_ready", i),    32'(rr_if.in_ready),        32'(tbl[i].in_ready));
            check($sformatf("row%0d valid_slave", i), 32'(rr_if.valid_slave),     32'(tbl[i].valid_slave));
            check($sformatf("row%0d addr_out", i),    32'(rr_if.addr_out),        32'(tbl[i].addr));
            check($sformatf("row%0d value_out", i),   32'(rr_if.value_out),       32'(tbl[i].value));
            check($sformatf("row%0d handshake", i),   32'(rr_if.handshake_slave), 32'(tbl[i].hs));
            check($sformatf("row%0d grant_id", i),    32'(rr_if.grant_id),        32'(tbl[i].grant));
            check($sformatf("row%0d busy", i),        32'(rr_if.busy),            32'(tbl[i].busy));
            check($sformatf("row%0d decode_err", i),  32'(rr_if.decode_err),      32'(tbl[i].derr));
        end
        rr_if.in_valid = '0;

        // ---------------- fixed priority: masters 0 and 3 together -------
        rst_n = 1'b0;
        step();
        rst_n             = 1'b1;
        fp_if.ready_slave = 4'b1111;
        fp_if.in_valid    = 4'b1001;
        fp_if.data_in     = 32'hD300_0009;   // m3 {3,2,3}, m0 {0,1,1}
        step();
        fp_if.in_valid = '0;
        check("fp capture in_ready", 32'(fp_if.in_ready), 32'h6);
        step();
        check("fp first grant", 32'(fp_if.grant_id),    32'd3);
        check("fp first valid", 32'(fp_if.valid_slave), 32'h8);
        check("fp first addr",  32'(fp_if.addr_out),    32'd2);
        check("fp first value", 32'(fp_if.value_out),   32'd3);
        step();
        check("fp first hs",    32'(fp_if.handshake_slave), 32'h8);
        step();
        check("fp second grant", 32'(fp_if.grant_id),        32'd0);
        check("fp second valid", 32'(fp_if.valid_slave),     32'h1);
        check("fp second addr",  32'(fp_if.addr_out),        32'd1);
        check("fp second value", 32'(fp_if.value_out),       32'd1);
        check("fp hs cleared",   32'(fp_if.handshake_slave), 32'h0);
        step();
        check("fp second hs",    32'(fp_if.handshake_slave), 32'h1);
        step();
        check("fp idle busy",    32'(fp_if.busy),            32'd0);
        check("fp idle hs",      32'(fp_if.handshake_slave), 32'h0);

        // ---------------- round-robin with continuous refill --------------
        rst_n = 1'b0;
        step();
        rst_n             = 1'b1;
        rr_if.ready_slave = 4'b1111;
        rr_if.data_in     = 32'hDB92_4900;   // master i -> {slv i, addr i, value i}
        exp_seq           = '{0, 1, 2, 3, 0, 1};
        got               = 0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            #1;
            rr_if.in_valid = rr_if.in_ready;
            step();
            if (rr_if.handshake_slave != 4'b0000) begin
                check($sformatf("rr grant #%0d", got), 32'(rr_if.grant_id), 32'(exp_seq[got]));
                check($sformatf("rr hs #%0d", got), 32'(rr_if.handshake_slave),
                      32'(1) << exp_seq[got]);
                got++;
            end
        end
        rr_if.in_valid = '0;
        check("rr handshake count", 32'(got), 32'd6);

        // ---------------- decode error with three slaves ------------------
        rst_n = 1'b0;
        step();
        rst_n             = 1'b1;
        n3_if.ready_slave = 3'b111;
        n3_if.in_valid    = 4'b0100;
        n3_if.data_in     = 32'h00CA_0000;   // m2 {3,1,2}: slave 3 does not exist
        step();
        n3_if.in_valid = '0;
        check("n3 capture in_ready", 32'(n3_if.in_ready),   32'hB);
        check("n3 capture derr",     32'(n3_if.decode_err), 32'd0);
        step();
        check("n3 derr pulse",       32'(n3_if.decode_err),  32'd1);
        check("n3 no valid",         32'(n3_if.valid_slave), 32'h0);
        check("n3 busy low",         32'(n3_if.busy),        32'd0);
        check("n3 in_ready back",    32'(n3_if.in_ready),    32'hF);
        step();
        check("n3 derr cleared",     32'(n3_if.decode_err),  32'd0);
        check("n3 still no valid",   32'(n3_if.valid_slave), 32'h0);
        check("n3 no handshake",     32'(n3_if.handshake_slave), 32'h0);
        check("n3 still idle",       32'(n3_if.busy),        32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
